wb_stage_buf: RTL and testbench
===============================

// Module: wb_stage_buf
// PURPOSE
//  Parametrised writeback stage: buffers up to DEPTH instructions from the MEM stage in an in-order
//  queue and retires them when the register-file write port grants (rf_wr_ready). Adds byte-strobe
//  writes, pipeline flush, ID-stage forwarding lookup over all queued entries, and a retire counter.
//  Sits between mem_stage and the regfile; drives the trace debug interface on each commit.
// PARAMETERS
//  DATA_W   32  result/register width; multiple of 8
//  ADDR_W   5   register address width
//  DEPTH    4   queue entries; power of two, >=2
//  NUM_RD   2   ID-stage forwarding lookup ports
//  CNT_W    32  retire counter width
// PORTS
//  clk              in   1                  clock
//  resetn           in   1                  asynchronous reset, active-low
//  ws_allowin       out  1                  queue can accept an entry this cycle
//  ms_to_ws_valid   in   1                  MEM stage presents an entry
//  ms_to_ws_bus     in   BUS_W              {strb[DATA_W/8], dest[ADDR_W], result[DATA_W], pc[32]}
//  ws_flush         in   1                  discard every queued entry
//  rf_wr_ready      in   1                  regfile write port granted this cycle
//  ws_to_rf_bus     out  DATA_W/8+ADDR_W+DATA_W  {rf_wstrb, rf_waddr, rf_wdata}
//  id_rs_addr       in   NUM_RD*ADDR_W      ID source register numbers
//  ws_fwd_hit       out  NUM_RD             queued producer found for port i
//  ws_fwd_stall     out  NUM_RD             youngest producer writes partial bytes; ID must stall
//  ws_fwd_data      out  NUM_RD*DATA_W      forwarded data (valid when hit & !stall)
//  ws_retire_cnt    out  CNT_W              instructions retired since reset
//  debug_wb_pc      out  32                 committing pc
//  debug_wb_rf_wen  out  DATA_W/8           committing byte enables (0 when none)
//  debug_wb_rf_wnum out  ADDR_W             committing dest
//  debug_wb_rf_wdata out DATA_W             committing result
// BEHAVIOUR
//  - Reset (resetn low, async): queue empty, pointers 0, ws_retire_cnt 0; ws_allowin 1; all
//    strobes/hits/stalls 0; debug/data outputs 0 (driven from zeroed storage).
//  - ws_allowin = (count != DEPTH); registered-state only, no comb path from rf_wr_ready.
//  - Push: ms_to_ws_valid & ws_allowin & !ws_flush -> entry written at tail, count+1 next cycle.
//  - Commit: queue non-empty & rf_wr_ready & !ws_flush -> head retires combinationally this cycle:
//    rf_wstrb = head.strb if head.dest!=0 else 0; rf_waddr/rf_wdata = head fields; debug_* mirror
//    it with debug_wb_rf_wen = rf_wstrb. Head pops next edge; ws_retire_cnt+1 (wraps at 2^CNT_W).
//  - No commit -> rf_wstrb=0, debug_wb_rf_wen=0; other debug fields hold head contents (don't care).
//  - Dest 0 or strb 0: still retires and counts, never writes.
//  - Push and commit same cycle: count unchanged; pointers both advance (mod DEPTH).
//  - Latency: entry pushed at edge N is committable in cycle N+1 at earliest (queue empty, ready=1).
//  - ws_flush: highest priority; no push, no commit, rf_wstrb=0 that cycle; queue empty next cycle.
//    Retire counter unaffected.
//  - Forwarding (combinational over valid entries): port i matches entries with dest==rs_i,
//    dest!=0, strb!=0; youngest match wins. hit=1; stall=1 if its strb not all ones; data=its
//    result. The committing head is included (still present in the cycle it retires).
//  - Queue full and rf_wr_ready=1: commit proceeds, ws_allowin rises next cycle.
// STRUCTURE
//  - mycpu.v defines: WS_BUS_WD(DATA_W,ADDR_W), WS_TO_RF_BUS_WD, field offset macros.
//  - Sub-module wb_queue: DEPTH-entry circular FIFO (storage, head/tail ptrs, count, flush clear),
//    exposing per-entry valid/dest/strb/result for the forwarding search in the parent.
// TESTING
//  1 Reset mid-stream: 3 entries queued, resetn low -> allowin=1, rf_wstrb=0, retire_cnt=0 at once.
//  2 rf_wr_ready=0, push 4 entries (DEPTH=4) -> allowin=0 after 4th; raise ready -> commits in order
//    pc 0x1c000000..0x1c00000c, one per cycle, allowin=1 cycle after first commit.
//  3 Entry dest=0 strb=0xF -> retires, rf_wstrb=0, debug_wb_rf_wen=0, retire_cnt +1.
//  4 Queue {r5=0x11 full, r5=0x22 full}, rs=5 -> hit=1, stall=0, data=0x22; newer r5 strb=0x3
//    -> stall=1.
//  5 ws_flush with 3 entries and rf_wr_ready=1 -> no write that cycle, empty next cycle,
//    concurrent push dropped, retire_cnt unchanged.
//  6 Simultaneous push/commit for 10 cycles at count=2 -> count stays 2, pointers wrap, order kept.

Source files
------------

// File: rtl/wb_stage_buf_pkg.sv
// Shared definitions for the writeback stage buffer: bus width helpers and
// the default parameter values used by the top and its queue.
package wb_stage_buf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_CNT_W  = 32;
    localparam int PC_W       = 32;

    // {strb, dest, result, pc} as presented by the MEM stage
    function automatic int ws_bus_w(input int data_w, input int addr_w);
        return data_w / 8 + addr_w + data_w + PC_W;
    endfunction

    // {rf_wstrb, rf_waddr, rf_wdata} towards the register file
    function automatic int ws_to_rf_bus_w(input int data_w, input int addr_w);
        return data_w / 8 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/wb_stage_buf_queue.sv
// In-order circular queue for the writeback stage. Entries are also exposed
// in age order (index 0 = head) so the parent can search for forwarding.
module wb_stage_buf_queue
    import wb_stage_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int SW    = DATA_W / 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [SW-1:0]           in_strb,
    input  logic [ADDR_W-1:0]       in_dest,
    input  logic [DATA_W-1:0]       in_result,
    input  logic [PC_W-1:0]         in_pc,
    output logic                    full,
    output logic                    empty,
    output logic [SW-1:0]           head_strb,
    output logic [ADDR_W-1:0]       head_dest,
    output logic [DATA_W-1:0]       head_result,
    output logic [PC_W-1:0]         head_pc,
    output logic [DEPTH-1:0]        ord_valid,
    output logic [DEPTH*ADDR_W-1:0] ord_dest,
    output logic [DEPTH*SW-1:0]     ord_strb,
    output logic [DEPTH*DATA_W-1:0] ord_result
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SW-1:0]     strb_r   [DEPTH];
    logic [ADDR_W-1:0] dest_r   [DEPTH];
    logic [DATA_W-1:0] result_r [DEPTH];
    logic [PC_W-1:0]   pc_r     [DEPTH];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic [PW-1:0]     idx_s;

    assign push_ok_s = push & ~flush & ~full;
    assign pop_ok_s  = pop & ~flush & ~empty;
    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});

    // Pointer and occupancy tracking; flush empties the queue in one edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_ok_s) tail_r <= tail_r + PW'(1);
            if (pop_ok_s)  head_r <= head_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; zeroed at reset so idle debug outputs read as zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                strb_r[i]   <= {SW{1'b0}};
                dest_r[i]   <= {ADDR_W{1'b0}};
                result_r[i] <= {DATA_W{1'b0}};
                pc_r[i]     <= {PC_W{1'b0}};
            end
        end else if (push_ok_s) begin
            strb_r[tail_r]   <= in_strb;
            dest_r[tail_r]   <= in_dest;
            result_r[tail_r] <= in_result;
            pc_r[tail_r]     <= in_pc;
        end else begin
            strb_r[tail_r]   <= strb_r[tail_r];
        end
    end

    assign head_strb   = strb_r[head_r];
    assign head_dest   = dest_r[head_r];
    assign head_result = result_r[head_r];
    assign head_pc     = pc_r[head_r];

    // Rotate storage into age order starting at the head
    always_comb begin
        idx_s      = head_r;
        ord_valid  = {DEPTH{1'b0}};
        ord_dest   = {(DEPTH*ADDR_W){1'b0}};
        ord_strb   = {(DEPTH*SW){1'b0}};
        ord_result = {(DEPTH*DATA_W){1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx_s                        = head_r + PW'(k);
            ord_valid[k]                 = (CW'(k) < count_r);
            ord_dest[k*ADDR_W +: ADDR_W] = dest_r[idx_s];
            ord_strb[k*SW +: SW]         = strb_r[idx_s];
            ord_result[k*DATA_W +: DATA_W] = result_r[idx_s];
        end
    end

endmodule

// File: rtl/wb_stage_buf.sv
// Writeback stage: queues MEM results, retires them in order to the regfile
// when granted, forwards queued results to ID and drives the trace port.
module wb_stage_buf
    import wb_stage_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    output logic                                        ws_allowin,
    input  logic                                        ms_to_ws_valid,
    input  logic [ws_bus_w(DATA_W, ADDR_W)-1:0]         ms_to_ws_bus,
    input  logic                                        ws_flush,
    input  logic                                        rf_wr_ready,
    output logic [ws_to_rf_bus_w(DATA_W, ADDR_W)-1:0]   ws_to_rf_bus,
    input  logic [NUM_RD*ADDR_W-1:0]                    id_rs_addr,
    output logic [NUM_RD-1:0]                           ws_fwd_hit,
    output logic [NUM_RD-1:0]                           ws_fwd_stall,
    output logic [NUM_RD*DATA_W-1:0]                    ws_fwd_data,
    output logic [CNT_W-1:0]                            ws_retire_cnt,
    output logic [PC_W-1:0]                             debug_wb_pc,
    output logic [DATA_W/8-1:0]                         debug_wb_rf_wen,
    output logic [ADDR_W-1:0]                           debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                           debug_wb_rf_wdata
);

    localparam int SW = DATA_W / 8;

    logic [SW-1:0]           in_strb_s;
    logic [ADDR_W-1:0]       in_dest_s;
    logic [DATA_W-1:0]       in_result_s;
    logic [PC_W-1:0]         in_pc_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    push_s;
    logic                    commit_s;
    logic [SW-1:0]           head_strb_s;
    logic [ADDR_W-1:0]       head_dest_s;
    logic [DATA_W-1:0]       head_result_s;
    logic [PC_W-1:0]         head_pc_s;
    logic [SW-1:0]           rf_wstrb_s;
    logic [DEPTH-1:0]        ord_valid_s;
    logic [DEPTH*ADDR_W-1:0] ord_dest_s;
    logic [DEPTH*SW-1:0]     ord_strb_s;
    logic [DEPTH*DATA_W-1:0] ord_result_s;
    logic                    match_s;
    logic [CNT_W-1:0]        retire_cnt_r;

    assign in_pc_s     = ms_to_ws_bus[PC_W-1:0];
    assign in_result_s = ms_to_ws_bus[PC_W +: DATA_W];
    assign in_dest_s   = ms_to_ws_bus[PC_W+DATA_W +: ADDR_W];
    assign in_strb_s   = ms_to_ws_bus[PC_W+DATA_W+ADDR_W +: SW];

    // allowin depends only on occupancy so the grant never loops back to MEM
    assign ws_allowin = ~full_s;
    assign push_s     = ms_to_ws_valid & ~full_s & ~ws_flush;
    assign commit_s   = ~empty_s & rf_wr_ready & ~ws_flush;
    assign rf_wstrb_s = (commit_s && head_dest_s != {ADDR_W{1'b0}}) ? head_strb_s : {SW{1'b0}};

    wb_stage_buf_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push_s),
        .pop         (commit_s),
        .flush       (ws_flush),
        .in_strb     (in_strb_s),
        .in_dest     (in_dest_s),
        .in_result   (in_result_s),
        .in_pc       (in_pc_s),
        .full        (full_s),
        .empty       (empty_s),
        .head_strb   (head_strb_s),
        .head_dest   (head_dest_s),
        .head_result (head_result_s),
        .head_pc     (head_pc_s),
        .ord_valid   (ord_valid_s),
        .ord_dest    (ord_dest_s),
        .ord_strb    (ord_strb_s),
        .ord_result  (ord_result_s)
    );

    assign ws_to_rf_bus      = {rf_wstrb_s, head_dest_s, head_result_s};
    assign debug_wb_pc       = head_pc_s;
    assign debug_wb_rf_wen   = rf_wstrb_s;
    assign debug_wb_rf_wnum  = head_dest_s;
    assign debug_wb_rf_wdata = head_result_s;
    assign ws_retire_cnt     = retire_cnt_r;

    // Count every retirement, including ones that write nothing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retire_cnt_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            retire_cnt_r <= retire_cnt_r + CNT_W'(1);
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    // Scan oldest to youngest so the youngest matching producer wins
    always_comb begin
        ws_fwd_hit   = {NUM_RD{1'b0}};
        ws_fwd_stall = {NUM_RD{1'b0}};
        ws_fwd_data  = {(NUM_RD*DATA_W){1'b0}};
        match_s      = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                match_s = ord_valid_s[k]
                        && (ord_dest_s[k*ADDR_W +: ADDR_W] == id_rs_addr[p*ADDR_W +: ADDR_W])
                        && (ord_dest_s[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})
                        && (ord_strb_s[k*SW +: SW] != {SW{1'b0}});
                ws_fwd_hit[p]   = ws_fwd_hit[p] | match_s;
                ws_fwd_stall[p] = match_s ? ~(&ord_strb_s[k*SW +: SW]) : ws_fwd_stall[p];
                ws_fwd_data[p*DATA_W +: DATA_W] = match_s ? ord_result_s[k*DATA_W +: DATA_W]
                                                          : ws_fwd_data[p*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: accepted pushes are queued in the bench
// and popped/compared whenever a commit is expected.
module tb_wb_stage_buf;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 32;

    typedef struct {
        logic [3:0]  strb;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } ent_t;

    logic                     clk;
    logic                     resetn;
    logic                     ws_allowin;
    logic                     ms_to_ws_valid;
    logic [72:0]              ms_to_ws_bus;
    logic                     ws_flush;
    logic                     rf_wr_ready;
    logic [40:0]              ws_to_rf_bus;
    logic [NUM_RD*ADDR_W-1:0] id_rs_addr;
    logic [NUM_RD-1:0]        ws_fwd_hit;
    logic [NUM_RD-1:0]        ws_fwd_stall;
    logic [NUM_RD*DATA_W-1:0] ws_fwd_data;
    logic [CNT_W-1:0]         ws_retire_cnt;
    logic [31:0]              debug_wb_pc;
    logic [3:0]               debug_wb_rf_wen;
    logic [4:0]               debug_wb_rf_wnum;
    logic [31:0]              debug_wb_rf_wdata;

    ent_t        sb[$];
    logic [31:0] exp_cnt;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    int          n_vec;
    int          n_err;

    wb_stage_buf #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH),
        .NUM_RD (NUM_RD), .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_flush          (ws_flush),
        .rf_wr_ready       (rf_wr_ready),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .id_rs_addr        (id_rs_addr),
        .ws_fwd_hit        (ws_fwd_hit),
        .ws_fwd_stall      (ws_fwd_stall),
        .ws_fwd_data       (ws_fwd_data),
        .ws_retire_cnt     (ws_retire_cnt),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [3:0] strb, input logic [4:0] dest,
                                input logic [31:0] res, input logic [31:0] pc);
        ent_t e;
        e.strb = strb; e.dest = dest; e.res = res; e.pc = pc;
        return e;
    endfunction

    // Expected forwarding from the scoreboard contents, head included
    task automatic check_fwd();
        logic [4:0]  rs;
        logic        hit;
        logic        stall;
        logic [31:0] data;
        for (int p = 0; p < NUM_RD; p++) begin
            rs = (p == 0) ? rs0 : rs1;
            hit = 1'b0; stall = 1'b0; data = 32'h0;
            for (int k = 0; k < sb.size(); k++) begin
                if (sb[k].dest == rs && sb[k].dest != 5'd0 && sb[k].strb != 4'h0) begin
                    hit = 1'b1;
                    stall = (sb[k].strb != 4'hF);
                    data = sb[k].res;
                end
            end
            chk($sformatf("fwd_hit%0d", p), 64'(ws_fwd_hit[p]), 64'(hit));
            if (hit) begin
                chk($sformatf("fwd_stall%0d", p), 64'(ws_fwd_stall[p]), 64'(stall));
                chk($sformatf("fwd_data%0d", p), 64'(ws_fwd_data[p*32 +: 32]), 64'(data));
            end
        end
    endtask

    // One clock cycle: drive at posedge+1, check mid-cycle, update model at edge
    task automatic drive(input logic v, input ent_t e, input logic fl, input logic rdy);
        logic exp_push;
        logic exp_commit;
        logic [3:0] wstrb;
        ent_t h;
        ms_to_ws_valid = v;
        ms_to_ws_bus   = {e.strb, e.dest, e.res, e.pc};
        ws_flush       = fl;
        rf_wr_ready    = rdy;
        id_rs_addr     = {rs1, rs0};
        #3;
        chk("allowin", 64'(ws_allowin), 64'(sb.size() != DEPTH));
        chk("retire_cnt", 64'(ws_retire_cnt), 64'(exp_cnt));
        check_fwd();
        exp_push   = v && !fl && (sb.size() != DEPTH);
        exp_commit = !fl && rdy && (sb.size() != 0);
        if (exp_commit) begin
            h = sb.pop_front();
            wstrb = (h.dest != 5'd0) ? h.strb : 4'h0;
            chk("rf_bus", 64'(ws_to_rf_bus), 64'({wstrb, h.dest, h.res}));
            chk("dbg_pc", 64'(debug_wb_pc), 64'(h.pc));
            chk("dbg_wen", 64'(debug_wb_rf_wen), 64'(wstrb));
            chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
            chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(h.res));
            exp_cnt = exp_cnt + 32'd1;
        end else begin
            chk("rf_wstrb_idle", 64'(ws_to_rf_bus[40:37]), 64'h0);
            chk("dbg_wen_idle", 64'(debug_wb_rf_wen), 64'h0);
        end
        if (fl) sb.delete();
        @(posedge clk);
        if (exp_push) sb.push_back(e);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, mk(4'h0, 5'd0, 32'h0, 32'h0), 1'b0, rdy);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately
    task automatic do_reset();
        ms_to_ws_valid = 1'b0;
        ws_flush       = 1'b0;
        rf_wr_ready    = 1'b1;
        resetn         = 1'b0;
        #2;
        chk("rst_allowin", 64'(ws_allowin), 64'h1);
        chk("rst_wstrb", 64'(ws_to_rf_bus[40:37]), 64'h0);
        chk("rst_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("rst_cnt", 64'(ws_retire_cnt), 64'h0);
        chk("rst_pc", 64'(debug_wb_pc), 64'h0);
        chk("rst_hit", 64'(ws_fwd_hit), 64'h0);
        sb.delete();
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_cnt = 32'd0;
        rs0 = 5'd5; rs1 = 5'd6;
        ms_to_ws_valid = 1'b0; ms_to_ws_bus = 73'h0; ws_flush = 1'b0;
        rf_wr_ready = 1'b0; id_rs_addr = 10'h0; resetn = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Fill with ready low, overflow attempt dropped, then drain in order
        for (int i = 0; i < 5; i++)
            drive(1'b1, mk(4'hF, 5'(i + 1), 32'hA000 + 32'(i), 32'h1c000000 + 32'(4 * i)), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Dest 0 retires and counts but never writes
        drive(1'b1, mk(4'hF, 5'd0, 32'hDEAD, 32'h1c000100), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++)
            drive(1'b1, mk(4'hF, 5'd7, 32'(i), 32'h1c000200 + 32'(4 * i)), 1'b0, 1'b0);
        do_reset();

        // Youngest producer wins; partial strobe forces a stall
        drive(1'b1, mk(4'hF, 5'd5, 32'h11, 32'h1c000300), 1'b0, 1'b0);
        drive(1'b1, mk(4'hF, 5'd5, 32'h22, 32'h1c000304), 1'b0, 1'b0);
        drive(1'b1, mk(4'hF, 5'd6, 32'h66, 32'h1c000308), 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b1, mk(4'h3, 5'd5, 32'h33, 32'h1c00030c), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush with entries queued, concurrent push and grant both dropped
        for (int i = 0; i < 3; i++)
            drive(1'b1, mk(4'hF, 5'd9, 32'h90 + 32'(i), 32'h1c000400 + 32'(4 * i)), 1'b0, 1'b0);
        drive(1'b1, mk(4'hF, 5'd10, 32'hBB, 32'h1c000500), 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Steady push+commit at occupancy two; pointers wrap several times
        for (int i = 0; i < 2; i++)
            drive(1'b1, mk(4'hF, 5'd3, 32'h300 + 32'(i), 32'h1c000600 + 32'(4 * i)), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(1'b1, mk(4'hF, 5'd4, 32'h400 + 32'(i), 32'h1c000700 + 32'(4 * i)), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random mix of everything
        for (int i = 0; i < 60; i++) begin
            rs0 = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)),
                  mk(4'($urandom), 5'($urandom_range(0, 3)), $urandom, 32'h1c001000 + 32'(4 * i)),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 5; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
